// File: rtl/dual_port_tcm_if.sv
// dual_port_tcm_if: one request/acknowledge port of the dual-port tightly coupled memory
interface dual_port_tcm_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 15
);
  logic                    cs;
  logic                    we;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH/8-1:0] be;
  logic                    data_valid;
  logic [DATA_WIDTH-1:0]   data_i;
  logic                    data_ready;
  logic [DATA_WIDTH-1:0]   data_o;
  modport master (output cs, we, addr, be, data_valid, data_i, input data_ready, data_o);
  modport slave (input cs, we, addr, be, data_valid, data_i, output data_ready, data_o);
endinterface

// File: rtl/dual_port_tcm.sv
// dual_port_tcm: read-first dual-port byte-writable memory with fixed-latency acknowledge pipelines
module dual_port_tcm #(
  parameter int    DATA_WIDTH = 32,
  parameter int    ADDR_WIDTH = 15,
  parameter int    LATENCY    = 1,
  parameter string INIT_FILE  = ""
) (
  input logic             clk,
  input logic             rst,
  dual_port_tcm_if.slave  a,
  dual_port_tcm_if.slave  b
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int OFF   = $clog2(NB);
  localparam int IW    = ADDR_WIDTH - OFF;
  localparam int WORDS = 1 << IW;
  logic [DATA_WIDTH-1:0] mem [WORDS];
  logic [1:0] cs, we, dv, acc, wr_en;
  logic [IW-1:0] idx [2];
  logic [NB-1:0] be [2];
  logic [DATA_WIDTH-1:0] wd [2];
  logic [1:0][LATENCY-1:0] vld_q, vld_d;
  logic [DATA_WIDTH-1:0] dat_q [2][LATENCY];
  logic [DATA_WIDTH-1:0] dat_d [2][LATENCY];
  initial for (int i = 0; i < WORDS; i++) mem[i] = '0;
  always_comb begin
    cs = {b.cs, a.cs};
    we = {b.we, a.we};
    dv = {b.data_valid, a.data_valid};
    idx[0] = a.addr[ADDR_WIDTH-1:OFF];
    idx[1] = b.addr[ADDR_WIDTH-1:OFF];
    be[0] = a.be;
    be[1] = b.be;
    wd[0] = a.data_i;
    wd[1] = b.data_i;
    acc = cs & ~{2{rst}} & (~we | dv);
    wr_en = acc & we;
    for (int p = 0; p < 2; p++) begin
      vld_d[p] = LATENCY'({vld_q[p], acc[p]});
      dat_d[p][0] = mem[idx[p]];
      for (int k = 1; k < LATENCY; k++) dat_d[p][k] = dat_q[p][k-1];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) vld_q <= '0;
    else vld_q <= vld_d;
    dat_q <= dat_d;
    for (int p = 1; p >= 0; p--)
      for (int i = 0; i < NB; i++)
        if (wr_en[p] && be[p][i]) mem[idx[p]][i*8 +: 8] <= wd[p][i*8 +: 8];
  end
  assign a.data_ready = vld_q[0][LATENCY-1] & ~rst;
  assign b.data_ready = vld_q[1][LATENCY-1] & ~rst;
  assign a.data_o = a.data_ready ? dat_q[0][LATENCY-1] : '0;
  assign b.data_o = b.data_ready ? dat_q[1][LATENCY-1] : '0;
endmodule

// File: tb/tb_dual_port_tcm.sv
// tb_dual_port_tcm: directed checks of a LATENCY=1 and a LATENCY=3 instance
module tb_dual_port_tcm;
  logic clk = 0;
  logic rst = 1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  dual_port_tcm_if #(.DATA_WIDTH(32), .ADDR_WIDTH(15)) i1a(), i1b(), i3a(), i3b();
  dual_port_tcm #(.LATENCY(1)) u1 (.clk(clk), .rst(rst), .a(i1a.slave), .b(i1b.slave));
  dual_port_tcm #(.LATENCY(3)) u3 (.clk(clk), .rst(rst), .a(i3a.slave), .b(i3b.slave));
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic idle();
    i1a.cs = 0; i1b.cs = 0; i3a.cs = 0; i3b.cs = 0;
  endtask
  task automatic r1a(input logic w, input logic v, input logic [14:0] ad, input logic [3:0] e, input logic [31:0] d);
    i1a.cs = 1; i1a.we = w; i1a.data_valid = v; i1a.addr = ad; i1a.be = e; i1a.data_i = d;
  endtask
  task automatic r1b(input logic w, input logic v, input logic [14:0] ad, input logic [3:0] e, input logic [31:0] d);
    i1b.cs = 1; i1b.we = w; i1b.data_valid = v; i1b.addr = ad; i1b.be = e; i1b.data_i = d;
  endtask
  task automatic r3a(input logic w, input logic v, input logic [14:0] ad, input logic [3:0] e, input logic [31:0] d);
    i3a.cs = 1; i3a.we = w; i3a.data_valid = v; i3a.addr = ad; i3a.be = e; i3a.data_i = d;
  endtask
  initial begin
    idle();
    i3b.we = 0; i3b.data_valid = 0; i3b.addr = '0; i3b.be = '0; i3b.data_i = '0;
    r1a(1, 1, 15'h100, 4'hF, 32'h12345678);
    tick(); tick();
    chk("rst_rdy1a", {31'd0, i1a.data_ready}, 32'd0);
    chk("rst_do1a", i1a.data_o, 32'd0);
    chk("rst_rdy3a", {31'd0, i3a.data_ready}, 32'd0);
    chk("rst_rdy1b", {31'd0, i1b.data_ready}, 32'd0);
    idle();
    rst = 0;
    r1a(1, 1, 15'h10, 4'hF, 32'hDEADBEEF);
    tick(); idle();
    chk("wr_ack_rdy", {31'd0, i1a.data_ready}, 32'd1);
    chk("wr_ack_old", i1a.data_o, 32'd0);
    r1b(0, 0, 15'h10, 4'h0, 32'd0);
    tick(); idle();
    chk("rd_b_rdy", {31'd0, i1b.data_ready}, 32'd1);
    chk("rd_b_data", i1b.data_o, 32'hDEADBEEF);
    chk("idle_a_rdy", {31'd0, i1a.data_ready}, 32'd0);
    chk("idle_a_do", i1a.data_o, 32'd0);
    r1a(1, 1, 15'h20, 4'hF, 32'h11223344);
    tick();
    r1a(1, 1, 15'h20, 4'h5, 32'hAABBCCDD);
    tick();
    chk("be_wr_old", i1a.data_o, 32'h11223344);
    r1a(0, 0, 15'h20, 4'h0, 32'd0);
    tick(); idle();
    chk("be_merge", i1a.data_o, 32'h11BB33DD);
    r1a(1, 1, 15'h40, 4'h3, 32'h000000FF);
    r1b(1, 1, 15'h40, 4'h6, 32'hFFFF0000);
    tick(); idle();
    chk("dual_wr_ack_b", {31'd0, i1b.data_ready}, 32'd1);
    chk("dual_wr_old_b", i1b.data_o, 32'd0);
    r1a(0, 0, 15'h40, 4'h0, 32'd0);
    tick(); idle();
    chk("dual_wr_merge", i1a.data_o, 32'h00FF00FF);
    r1a(1, 0, 15'h40, 4'hF, 32'h12345678);
    tick(); idle();
    chk("noop_no_ack", {31'd0, i1a.data_ready}, 32'd0);
    r1a(1, 1, 15'h40, 4'hF, 32'hCAFEF00D);
    r1b(0, 0, 15'h40, 4'h0, 32'd0);
    tick(); idle();
    chk("rf_same_cyc", i1b.data_o, 32'h00FF00FF);
    r1b(0, 0, 15'h43, 4'h0, 32'd0);
    tick(); idle();
    chk("low_bits_ign", i1b.data_o, 32'hCAFEF00D);
    r1b(0, 0, 15'h100, 4'h0, 32'd0);
    tick(); idle();
    chk("no_acc_in_rst", i1b.data_o, 32'd0);
    chk("no_acc_rdy", {31'd0, i1b.data_ready}, 32'd1);
    r3a(1, 1, 15'h0, 4'hF, 32'hA0A0A0A0);
    tick();
    r3a(1, 1, 15'h4, 4'hF, 32'hB1B1B1B1);
    tick();
    r3a(1, 1, 15'h8, 4'hF, 32'hC2C2C2C2);
    tick(); idle();
    tick(); tick(); tick();
    chk("l3_drained", {31'd0, i3a.data_ready}, 32'd0);
    r3a(0, 0, 15'h0, 4'h0, 32'd0);
    tick();
    chk("l3_lat_c1", {31'd0, i3a.data_ready}, 32'd0);
    r3a(0, 0, 15'h4, 4'h0, 32'd0);
    tick();
    chk("l3_lat_c2", {31'd0, i3a.data_ready}, 32'd0);
    r3a(0, 0, 15'h8, 4'h0, 32'd0);
    tick(); idle();
    chk("l3_rdy0", {31'd0, i3a.data_ready}, 32'd1);
    chk("l3_d0", i3a.data_o, 32'hA0A0A0A0);
    tick();
    chk("l3_rdy1", {31'd0, i3a.data_ready}, 32'd1);
    chk("l3_d1", i3a.data_o, 32'hB1B1B1B1);
    tick();
    chk("l3_rdy2", {31'd0, i3a.data_ready}, 32'd1);
    chk("l3_d2", i3a.data_o, 32'hC2C2C2C2);
    tick();
    chk("l3_rdy_end", {31'd0, i3a.data_ready}, 32'd0);
    r3a(0, 0, 15'h4, 4'h0, 32'd0);
    r1a(1, 1, 15'h80, 4'hF, 32'h5555AAAA);
    tick(); idle();
    rst = 1;
    tick();
    chk("flush_in_rst", {31'd0, i3a.data_ready}, 32'd0);
    rst = 0;
    tick();
    chk("flush_rdy", {31'd0, i3a.data_ready}, 32'd0);
    chk("flush_do", i3a.data_o, 32'd0);
    tick();
    chk("flush_rdy2", {31'd0, i3a.data_ready}, 32'd0);
    r3a(0, 0, 15'h4, 4'h0, 32'd0);
    r1a(0, 0, 15'h80, 4'h0, 32'd0);
    tick(); idle();
    chk("pre_rst_wr", i1a.data_o, 32'h5555AAAA);
    tick(); tick();
    chk("post_rst_rd", i3a.data_o, 32'hB1B1B1B1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
